// File: rtl/shift_arb_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_arb_seq
// Brief    : Two-port arbitrated multi-cycle SLL/SRL/SRA engine, one barrel
//            stage (16/8/4/2/1) per clock, valid/ready response channel.
//            Optional macro SHIFT_EARLY_DONE_EN skips trailing idle stages.
// Revision : 1.0 - initial release
// ============================================================================
module shift_arb_seq #(
   parameter int FIXED_PRIO = 0,
   parameter int RR_INIT    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [1:0]  req0_op,
   input  logic [4:0]  req0_amt,
   input  logic [31:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [1:0]  req1_op,
   input  logic [4:0]  req1_amt,
   input  logic [31:0] req1_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [31:0] resp_result,
   output logic        busy
);

   localparam logic [1:0] c_OP_SLL = 2'b00;
   localparam logic [1:0] c_OP_SRL = 2'b01;
   localparam logic [1:0] c_OP_SRA = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_stage;
   logic [1:0]  r_op;
   logic [4:0]  r_amt;
   logic [31:0] r_work;
   logic        r_sign;
   logic        r_last_grant;
   logic        r_resp_id;

   logic        w_grant;
   logic        w_any_valid;
   logic        w_accept;
   logic        w_stage_en;
   logic        w_last_stage;
   logic [4:0]  w_step;
   logic [31:0] w_fill_mask;
   logic [31:0] w_shifted;

   assign w_any_valid = req0_valid | req1_valid;
   assign w_accept    = (r_state == S_IDLE) && w_any_valid;

   always_comb begin
      w_grant = 1'b0;
      if (req1_valid && !req0_valid) begin
         w_grant = 1'b1;
      end else if (req0_valid && req1_valid && (FIXED_PRIO == 0)) begin
         w_grant = ~r_last_grant;
      end
   end

   assign req0_ready = (r_state == S_IDLE) && !w_grant && req0_valid;
   assign req1_ready = (r_state == S_IDLE) &&  w_grant && req1_valid;

   // Stage k applies a shift of 16>>k when amt bit (4-k) is set
   always_comb begin
      w_stage_en = 1'b0;
      case (r_stage)
         3'd0:    w_stage_en = r_amt[4];
         3'd1:    w_stage_en = r_amt[3];
         3'd2:    w_stage_en = r_amt[2];
         3'd3:    w_stage_en = r_amt[1];
         3'd4:    w_stage_en = r_amt[0];
         default: w_stage_en = 1'b0;
      endcase
   end

   assign w_step      = 5'd16 >> r_stage;
   assign w_fill_mask = ~(32'hFFFF_FFFF >> w_step);

   // SRA fills from the sign captured at acceptance
   always_comb begin
      w_shifted = r_work;
      if (w_stage_en) begin
         case (r_op)
            c_OP_SLL: w_shifted = r_work << w_step;
            c_OP_SRL: w_shifted = r_work >> w_step;
            c_OP_SRA: w_shifted = (r_work >> w_step) | (r_sign ? w_fill_mask : 32'd0);
            default:  w_shifted = r_work;
         endcase
      end
   end

`ifdef SHIFT_EARLY_DONE_EN
   assign w_last_stage = ((r_amt & (5'h0F >> r_stage)) == 5'd0);
`else
   assign w_last_stage = (r_stage == 3'd4);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last_stage) w_state_nxt = S_DONE;
         S_DONE:  if (resp_ready)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stage      <= 3'd0;
         r_op         <= 2'b00;
         r_amt        <= 5'd0;
         r_work       <= 32'd0;
         r_sign       <= 1'b0;
         r_resp_id    <= 1'b0;
         r_last_grant <= (RR_INIT != 0);
      end else if (w_accept) begin
         r_op         <= w_grant ? req1_op   : req0_op;
         r_amt        <= w_grant ? req1_amt  : req0_amt;
         r_work       <= w_grant ? req1_data : req0_data;
         r_sign       <= w_grant ? req1_data[31] : req0_data[31];
         r_resp_id    <= w_grant;
         r_last_grant <= w_grant;
         r_stage      <= 3'd0;
      end else if (r_state == S_RUN) begin
         r_work       <= w_shifted;
         r_stage      <= r_stage + 3'd1;
      end
   end

   assign resp_valid  = (r_state == S_DONE);
   assign resp_result = resp_valid ? r_work : 32'd0;
   assign resp_id     = r_resp_id;
   assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
